// File: rtl/cond_logic_mt.sv
// cond_logic_mt
//   Multi-context condition/flag unit. It keeps one committed NZCV set per
//   hardware context and evaluates the ARM condition of the issuing
//   instruction against it. Same-cycle writeback flags are forwarded into
//   the evaluation. In-flight flag writes are counted per (context, group),
//   and issue stalls while a needed group is unresolved.
//
// Ports
//   CLK, RST         clock, asynchronous active-high reset
//   Valid/Ctx/Cond   issuing instruction, its context and condition field
//   PCS/RegW/MemW/NoWrite/FlagW   decoder controls (FlagW[1]=NZ, [0]=CV)
//   Flush            kill in-flight work, suppress issue this cycle
//   WbFlagW/WbCtx/WbFlags         retiring flag write {N,Z,C,V}
//   PCSrc/RegWrite/MemWrite       gated controls
//   IssueFlagW       effective flag-write mask carried to writeback
//   Stall            decode hold
//   FlagsOut         committed flags of context Ctx (no forwarding)
//
// Handshake: an instruction is accepted in a cycle where Valid=1, Stall=0
// and Flush=0. While Stall=1 decode holds its inputs stable, and the unit
// produces no side effects for that instruction.
module cond_logic_mt #(
    parameter int CTX_W = 2,
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Valid,
    input  logic [CTX_W-1:0] Ctx,
    input  logic [3:0]       Cond,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic [1:0]       FlagW,
    input  logic             Flush,
    input  logic [1:0]       WbFlagW,
    input  logic [CTX_W-1:0] WbCtx,
    input  logic [3:0]       WbFlags,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       IssueFlagW,
    output logic             Stall,
    output logic [3:0]       FlagsOut
);

    localparam int NUM_CTX = 1 << CTX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CTX-1:0][3:0]       flags_q, flags_d;
    logic [NUM_CTX-1:0][CNT_W-1:0] pend_nz_q, pend_nz_d;
    logic [NUM_CTX-1:0][CNT_W-1:0] pend_cv_q, pend_cv_d;

    logic [CNT_W-1:0] cur_nz, cur_cv;
    logic             wb_nz_hit, wb_cv_hit;
    logic             flag_n, flag_z, flag_c, flag_v;
    logic             need_nz, need_cv, cond_true;
    logic             busy_nz, busy_cv, full_nz, full_cv;
    logic             stall_int, issue, cond_ex;
    logic [NUM_CTX-1:0] inc_nz_v, inc_cv_v, dec_nz_v, dec_cv_v;

    // Issue-side evaluation
    always_comb begin
        cur_nz    = pend_nz_q[Ctx];
        cur_cv    = pend_cv_q[Ctx];
        wb_nz_hit = WbFlagW[1] && (WbCtx == Ctx);
        wb_cv_hit = WbFlagW[0] && (WbCtx == Ctx);

        // Zero-cycle forward from the writeback port, per flag group
        flag_n = wb_nz_hit ? WbFlags[3] : flags_q[Ctx][3];
        flag_z = wb_nz_hit ? WbFlags[2] : flags_q[Ctx][2];
        flag_c = wb_cv_hit ? WbFlags[1] : flags_q[Ctx][1];
        flag_v = wb_cv_hit ? WbFlags[0] : flags_q[Ctx][0];

        need_nz   = 1'b0;
        need_cv   = 1'b0;
        cond_true = 1'b0;
        case (Cond)
            4'b0000: begin need_nz = 1'b1; cond_true = flag_z;  end
            4'b0001: begin need_nz = 1'b1; cond_true = ~flag_z; end
            4'b0010: begin need_cv = 1'b1; cond_true = flag_c;  end
            4'b0011: begin need_cv = 1'b1; cond_true = ~flag_c; end
            4'b0100: begin need_nz = 1'b1; cond_true = flag_n;  end
            4'b0101: begin need_nz = 1'b1; cond_true = ~flag_n; end
            4'b0110: begin need_cv = 1'b1; cond_true = flag_v;  end
            4'b0111: begin need_cv = 1'b1; cond_true = ~flag_v; end
            4'b1000: begin need_nz = 1'b1; need_cv = 1'b1; cond_true = flag_c & ~flag_z;    end
            4'b1001: begin need_nz = 1'b1; need_cv = 1'b1; cond_true = ~flag_c | flag_z;    end
            4'b1010: begin need_nz = 1'b1; need_cv = 1'b1; cond_true = (flag_n == flag_v);  end
            4'b1011: begin need_nz = 1'b1; need_cv = 1'b1; cond_true = (flag_n != flag_v);  end
            4'b1100: begin need_nz = 1'b1; need_cv = 1'b1; cond_true = ~flag_z & (flag_n == flag_v); end
            4'b1101: begin need_nz = 1'b1; need_cv = 1'b1; cond_true = flag_z | (flag_n != flag_v);  end
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase

        // Effective pending > 0: a count of one retiring this cycle is resolved
        busy_nz = (cur_nz != '0) && !((cur_nz == CNT_W'(1)) && wb_nz_hit);
        busy_cv = (cur_cv != '0) && !((cur_cv == CNT_W'(1)) && wb_cv_hit);
        // Full check uses the raw count so the counter can never wrap
        full_nz = (cur_nz == CNT_MAX);
        full_cv = (cur_cv == CNT_MAX);

        stall_int = Valid & ~Flush & ~RST &
                    ((need_nz & busy_nz) | (need_cv & busy_cv) |
                     (FlagW[1] & full_nz) | (FlagW[0] & full_cv));
        issue   = Valid & ~stall_int & ~Flush & ~RST;
        cond_ex = issue & cond_true;
    end

    assign PCSrc      = cond_ex & PCS;
    assign RegWrite   = cond_ex & RegW & ~NoWrite;
    assign MemWrite   = cond_ex & MemW;
    assign IssueFlagW = FlagW & {2{cond_ex}};
    assign Stall      = stall_int;
    assign FlagsOut   = RST ? 4'b0000 : flags_q[Ctx];

    // Next state
    always_comb begin
        flags_d   = flags_q;
        pend_nz_d = pend_nz_q;
        pend_cv_d = pend_cv_q;

        if (WbFlagW[1]) flags_d[WbCtx][3:2] = WbFlags[3:2];
        if (WbFlagW[0]) flags_d[WbCtx][1:0] = WbFlags[1:0];

        inc_nz_v = IssueFlagW[1] ? (NUM_CTX'(1) << Ctx)   : '0;
        inc_cv_v = IssueFlagW[0] ? (NUM_CTX'(1) << Ctx)   : '0;
        dec_nz_v = WbFlagW[1]    ? (NUM_CTX'(1) << WbCtx) : '0;
        dec_cv_v = WbFlagW[0]    ? (NUM_CTX'(1) << WbCtx) : '0;

        for (int i = 0; i < NUM_CTX; i++) begin
            if (Flush) begin
                pend_nz_d[i] = '0;
                pend_cv_d[i] = '0;
            end else begin
                // Simultaneous inc and dec cancel; dec of zero saturates at 0
                if (inc_nz_v[i] && !dec_nz_v[i])
                    pend_nz_d[i] = pend_nz_q[i] + CNT_W'(1);
                else if (dec_nz_v[i] && !inc_nz_v[i] && pend_nz_q[i] != '0)
                    pend_nz_d[i] = pend_nz_q[i] - CNT_W'(1);
                if (inc_cv_v[i] && !dec_cv_v[i])
                    pend_cv_d[i] = pend_cv_q[i] + CNT_W'(1);
                else if (dec_cv_v[i] && !inc_cv_v[i] && pend_cv_q[i] != '0)
                    pend_cv_d[i] = pend_cv_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flags_q   <= '0;
            pend_nz_q <= '0;
            pend_cv_q <= '0;
        end else begin
            flags_q   <= flags_d;
            pend_nz_q <= pend_nz_d;
            pend_cv_q <= pend_cv_d;
        end
    end

endmodule

// File: tb/tb_cond_logic_mt.sv
// Directed bench for cond_logic_mt (CTX_W=2, CNT_W=2). Inputs change on the
// falling edge; combinational outputs are checked 2 time units later, well
// before the next rising edge.
module tb_cond_logic_mt;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Valid;
    logic [1:0] Ctx;
    logic [3:0] Cond;
    logic       PCS, RegW, MemW, NoWrite;
    logic [1:0] FlagW;
    logic       Flush;
    logic [1:0] WbFlagW;
    logic [1:0] WbCtx;
    logic [3:0] WbFlags;
    logic       PCSrc, RegWrite, MemWrite;
    logic [1:0] IssueFlagW;
    logic       Stall;
    logic [3:0] FlagsOut;

    int checks = 0;
    int errors = 0;

    cond_logic_mt #(.CTX_W(2), .CNT_W(2)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .Ctx(Ctx), .Cond(Cond),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .FlagW(FlagW), .Flush(Flush), .WbFlagW(WbFlagW), .WbCtx(WbCtx),
        .WbFlags(WbFlags), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .IssueFlagW(IssueFlagW), .Stall(Stall),
        .FlagsOut(FlagsOut)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        Valid = 0; Ctx = 0; Cond = 4'b1110; PCS = 0; RegW = 0; MemW = 0;
        NoWrite = 0; FlagW = 0; Flush = 0; WbFlagW = 0; WbCtx = 0; WbFlags = 0;
    endtask

    // Start a new cycle: falling edge, all inputs idle
    task automatic cyc();
        @(negedge CLK);
        clr();
    endtask

    initial begin
        RST = 0;
        clr();
        #1 RST = 1;
        // Outputs held low during reset even with a valid AL instruction
        Valid = 1; RegW = 1; PCS = 1; MemW = 1; FlagW = 2'b11;
        #2;
        chk("rst_stall", Stall, 0);
        chk("rst_regw", RegWrite, 0);
        chk("rst_pcsrc", PCSrc, 0);
        chk("rst_ifw", IssueFlagW, 0);
        chk("rst_flags", FlagsOut, 0);
        @(negedge CLK); clr(); RST = 0;

        // EQ with Z=0 -> not executed
        Valid = 1; Cond = 4'b0000; PCS = 1; #2;
        chk("eq_z0_pcsrc", PCSrc, 0);
        chk("eq_z0_stall", Stall, 0);
        // NE with Z=0 -> executed
        Cond = 4'b0001; #1;
        chk("ne_z0_pcsrc", PCSrc, 1);

        cyc(); Valid = 1; Cond = 4'b1110; RegW = 1; MemW = 1; #2;
        chk("al_regw", RegWrite, 1);
        chk("al_memw", MemWrite, 1);
        NoWrite = 1; #1;
        chk("al_nowrite", RegWrite, 0);

        cyc(); Valid = 1; Cond = 4'b1111; PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11; #2;
        chk("nv_out", {PCSrc, RegWrite, MemWrite, IssueFlagW}, 5'b00000);

        // CMP on ctx0 -> pend_nz[0]=pend_cv[0]=1
        cyc(); Valid = 1; Cond = 4'b1110; FlagW = 2'b11; #2;
        chk("cmp_ifw", IssueFlagW, 2'b11);

        // BEQ ctx0 stalls; BEQ ctx1 does not
        cyc(); Valid = 1; Ctx = 0; Cond = 4'b0000; PCS = 1; #2;
        chk("beq0_stall", Stall, 1);
        chk("beq0_pcsrc", PCSrc, 0);
        Ctx = 1; #1;
        chk("beq1_stall", Stall, 0);
        chk("beq1_pcsrc", PCSrc, 0);

        // Bypass: NZ retiring in same cycle, Z=1
        cyc(); Valid = 1; Ctx = 0; Cond = 4'b0000; PCS = 1;
        WbCtx = 0; WbFlagW = 2'b10; WbFlags = 4'b0100; #2;
        chk("byp_stall", Stall, 0);
        chk("byp_pcsrc", PCSrc, 1);

        // Committed Z visible; CV still pending -> CS stalls
        cyc(); Ctx = 0; #2;
        chk("byp_flags", FlagsOut, 4'b0100);
        Valid = 1; Cond = 4'b0010; PCS = 1; #1;
        chk("cs_pend_stall", Stall, 1);

        // Add an NZ-pending write, then flush with simultaneous CV writeback
        cyc(); Valid = 1; Ctx = 0; Cond = 4'b1110; FlagW = 2'b10; #2;
        chk("nzw_ifw", IssueFlagW, 2'b10);
        cyc(); Valid = 1; Ctx = 0; Cond = 4'b1110; RegW = 1; FlagW = 2'b11; Flush = 1;
        WbCtx = 0; WbFlagW = 2'b01; WbFlags = 4'b0011; #2;
        chk("fl_stall", Stall, 0);
        chk("fl_regw", RegWrite, 0);
        chk("fl_ifw", IssueFlagW, 0);
        cyc(); Ctx = 0; #2;
        chk("fl_flags", FlagsOut, 4'b0111);
        Valid = 1; Cond = 4'b1000; PCS = 1; #1;   // HI: C & ~Z = 0
        chk("fl_hi_stall", Stall, 0);
        chk("fl_hi_pcsrc", PCSrc, 0);
        Cond = 4'b0010; #1;                        // CS: C = 1
        chk("fl_cs_pcsrc", PCSrc, 1);

        // Ctx2 saturation: three issues fill the counter
        for (int k = 0; k < 3; k++) begin
            cyc(); Valid = 1; Ctx = 2; Cond = 4'b1110; FlagW = 2'b11; #2;
            chk($sformatf("sat_issue%0d", k), {Stall, IssueFlagW}, 3'b011);
        end
        cyc(); Valid = 1; Ctx = 2; Cond = 4'b1110; FlagW = 2'b11; #2;
        chk("sat_full_stall", Stall, 1);
        chk("sat_full_ifw", IssueFlagW, 0);
        Cond = 4'b0100; FlagW = 0; #1;            // MI needs NZ, pending
        chk("sat_mi_stall", Stall, 1);
        // Writeback while full: issue still blocked, counter drops to 2
        Cond = 4'b1110; FlagW = 2'b11; WbCtx = 2; WbFlagW = 2'b11; WbFlags = 4'b1000; #1;
        chk("sat_wbfull_stall", Stall, 1);
        // Writeback plus issue: counter stays at 2
        cyc(); Valid = 1; Ctx = 2; Cond = 4'b1110; FlagW = 2'b11;
        WbCtx = 2; WbFlagW = 2'b11; WbFlags = 4'b1000; #2;
        chk("sat_wbiss_stall", Stall, 0);
        chk("sat_wbiss_ifw", IssueFlagW, 2'b11);
        chk("sat_flags2", FlagsOut, 4'b1000);
        cyc(); Valid = 1; Ctx = 2; Cond = 4'b1110; FlagW = 2'b11; #2;
        chk("sat_refill", Stall, 0);
        cyc(); Valid = 1; Ctx = 2; Cond = 4'b1110; FlagW = 2'b11; #1;
        chk("sat_full2", Stall, 1);

        // Asynchronous reset mid-stall
        #1 RST = 1;
        #1;
        chk("arst_stall", Stall, 0);
        chk("arst_out", {PCSrc, RegWrite, MemWrite, IssueFlagW}, 5'b00000);
        chk("arst_flags", FlagsOut, 0);
        @(negedge CLK); clr(); RST = 0;
        Ctx = 2; #2;
        chk("post_flags2", FlagsOut, 0);
        Ctx = 0; #1;
        chk("post_flags0", FlagsOut, 0);
        Ctx = 2; Valid = 1; Cond = 4'b1110; FlagW = 2'b11; #1;
        chk("post_stall", Stall, 0);
        chk("post_ifw", IssueFlagW, 2'b11);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
